// File: rtl/final_controller.sv
// Traffic-light control FSM: sequences the north/east phases with a phase timer
// and emits a one-cycle lamp write pulse into final_datapath on every state entry.
module final_controller #(
    parameter int TW        = 8,
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       not_r,
    input  logic       c_and_l,
    input  logic       en_s,
    input  logic       l_or_notc,
    output logic       s_NR,
    output logic       s_NG,
    output logic       s_NY,
    output logic       s_ER,
    output logic       s_EG,
    output logic       s_EY,
    output logic       en_NR,
    output logic       en_NG,
    output logic       en_NY,
    output logic       en_ER,
    output logic       en_EG,
    output logic       en_EY,
    output logic [1:0] s_IC,
    output logic       en_IC,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        AR_TO_N  = 3'd1,
        N_GREEN  = 3'd2,
        N_YELLOW = 3'd3,
        AR_TO_E  = 3'd4,
        E_GREEN  = 3'd5,
        E_YELLOW = 3'd6,
        OVERRIDE = 3'd7
    } state_t;

    // Terminal timer values: a phase ends on the edge where timer == duration-1.
    localparam logic [TW-1:0] ALLRED_END = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] YELLOW_END = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] GMIN_END   = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_END   = TW'(GREEN_MAX - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [5:0]    lamp_s_q, lamp_s_d;
    logic [5:0]    lamp_en_q, lamp_en_d;
    logic          n_green_done, e_green_done;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        return (t == {TW{1'b1}}) ? t : t + 1'b1;
    endfunction

    // Lamp pattern ordered {NR, NG, NY, ER, EG, EY}.
    function automatic logic [5:0] lamp_pattern(input state_t s);
        case (s)
            N_GREEN:  return 6'b010100;
            N_YELLOW: return 6'b001100;
            E_GREEN:  return 6'b100010;
            E_YELLOW: return 6'b100001;
            INIT:     return 6'b000000;
            default:  return 6'b100100;
        endcase
    endfunction

    assign n_green_done = ((timer_q >= GMIN_END) && c_and_l) || (timer_q == GMAX_END);
    assign e_green_done = ((timer_q >= GMIN_END) && l_or_notc) || (timer_q == GMAX_END);

    always_comb begin
        state_d = state_q;
        if (!not_r && state_q != OVERRIDE) begin
            state_d = OVERRIDE;
        end else if (state_q == OVERRIDE) begin
            if (not_r) state_d = AR_TO_N;
        end else if (en_s) begin
            case (state_q)
                INIT:     state_d = AR_TO_N;
                AR_TO_N:  if (timer_q == ALLRED_END) state_d = N_GREEN;
                N_GREEN:  if (n_green_done)          state_d = N_YELLOW;
                N_YELLOW: if (timer_q == YELLOW_END) state_d = AR_TO_E;
                AR_TO_E:  if (timer_q == ALLRED_END) state_d = E_GREEN;
                E_GREEN:  if (e_green_done)          state_d = E_YELLOW;
                E_YELLOW: if (timer_q == YELLOW_END) state_d = AR_TO_N;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        timer_d   = timer_q;
        lamp_s_d  = '0;
        lamp_en_d = '0;
        if (state_d != state_q) begin
            timer_d = '0;
            if (state_d != INIT) begin
                lamp_en_d = '1;
                lamp_s_d  = lamp_pattern(state_d);
            end
        end else if (en_s) begin
            timer_d = sat_inc(timer_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            timer_q   <= '0;
            lamp_s_q  <= '0;
            lamp_en_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lamp_s_q  <= lamp_s_d;
            lamp_en_q <= lamp_en_d;
        end
    end

    // Indicator controls are decoded straight from the current state.
    always_comb begin
        s_IC  = 2'b00;
        en_IC = 1'b0;
        case (state_q)
            N_GREEN:  begin s_IC = 2'b10; en_IC = en_s; end
            E_GREEN:  begin s_IC = 2'b11; en_IC = en_s; end
            OVERRIDE: begin s_IC = 2'b01; en_IC = 1'b1; end
            default:  begin s_IC = 2'b00; en_IC = 1'b0; end
        endcase
    end

    assign {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY}       = lamp_s_q;
    assign {en_NR, en_NG, en_NY, en_ER, en_EG, en_EY} = lamp_en_q;
    assign state = state_q;

endmodule

// File: tb/tb_final_controller.sv
// Scoreboard bench for final_controller: a cycle model pushes expected outputs
// when inputs are driven; they are popped and compared after each clock edge.
module tb_final_controller;

    localparam int TW = 8, GREEN_MIN = 8, GREEN_MAX = 32, YELLOW_T = 4, ALLRED_T = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       not_r, c_and_l, en_s, l_or_notc;
    logic       s_NR, s_NG, s_NY, s_ER, s_EG, s_EY;
    logic       en_NR, en_NG, en_NY, en_ER, en_EG, en_EY;
    logic [1:0] s_IC;
    logic       en_IC;
    logic [2:0] state;

    final_controller #(
        .TW(TW), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
    ) dut (
        .clk(clk), .rst(rst), .not_r(not_r), .c_and_l(c_and_l), .en_s(en_s),
        .l_or_notc(l_or_notc),
        .s_NR(s_NR), .s_NG(s_NG), .s_NY(s_NY), .s_ER(s_ER), .s_EG(s_EG), .s_EY(s_EY),
        .en_NR(en_NR), .en_NG(en_NG), .en_NY(en_NY), .en_ER(en_ER), .en_EG(en_EG),
        .en_EY(en_EY), .s_IC(s_IC), .en_IC(en_IC), .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // Expected record: {state[2:0], s[5:0], en[5:0], s_IC[1:0], en_IC}
    logic [17:0] exp_q[$];
    logic [5:0]  pat_tbl[8] = '{6'b000000, 6'b100100, 6'b010100, 6'b001100,
                                6'b100100, 6'b100010, 6'b100001, 6'b100100};
    logic [2:0]  ms;
    int          mt;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [17:0] observed();
        return {state, s_NR, s_NG, s_NY, s_ER, s_EG, s_EY,
                en_NR, en_NG, en_NY, en_ER, en_EG, en_EY, s_IC, en_IC};
    endfunction

    // Advance the reference model one edge with the current inputs and queue its outputs.
    task automatic model_step();
        logic [2:0]  ns;
        logic [5:0]  es_v, en_v;
        logic [1:0]  sic;
        logic        enic;
        bit          gmin;
        ns   = ms;
        gmin = (mt >= GREEN_MIN - 1);
        if (!not_r && ms != 3'd7)    ns = 3'd7;
        else if (ms == 3'd7)         ns = not_r ? 3'd1 : 3'd7;
        else if (en_s) begin
            case (ms)
                3'd0: ns = 3'd1;
                3'd1: if (mt == ALLRED_T - 1) ns = 3'd2;
                3'd2: if ((gmin && c_and_l) || mt == GREEN_MAX - 1) ns = 3'd3;
                3'd3: if (mt == YELLOW_T - 1) ns = 3'd4;
                3'd4: if (mt == ALLRED_T - 1) ns = 3'd5;
                3'd5: if ((gmin && l_or_notc) || mt == GREEN_MAX - 1) ns = 3'd6;
                3'd6: if (mt == YELLOW_T - 1) ns = 3'd1;
                default: ns = ms;
            endcase
        end
        es_v = '0;
        en_v = '0;
        if (ns != ms) begin
            mt = 0;
            if (ns != 3'd0) begin
                es_v = pat_tbl[ns];
                en_v = 6'h3F;
            end
        end else if (en_s && mt < (1 << TW) - 1) begin
            mt = mt + 1;
        end
        ms   = ns;
        sic  = (ms == 3'd2) ? 2'b10 : (ms == 3'd5) ? 2'b11 : (ms == 3'd7) ? 2'b01 : 2'b00;
        enic = ((ms == 3'd2 || ms == 3'd5) && en_s) || ms == 3'd7;
        exp_q.push_back({ms, es_v, en_v, sic, enic});
    endtask

    task automatic cyc();
        logic [17:0] e;
        model_step();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle", {14'd0, observed()}, {14'd0, e});
        if (en_NR | en_NG | en_NY | en_ER | en_EG | en_EY) pulses++;
    endtask

    task automatic goto_state(input logic [2:0] st);
        int guard = 0;
        while (state !== st && guard < 300) begin cyc(); guard++; end
        if (guard >= 300) check_eq("goto_bound", guard, 0);
    endtask

    // Number of observed cycles spent in st (waiting for its entry first).
    task automatic measure(input logic [2:0] st, output int n);
        int guard = 0;
        n = 0;
        while (state !== st && guard < 300) begin cyc(); guard++; end
        while (state === st && guard < 300) begin n++; cyc(); guard++; end
        if (guard >= 300) check_eq("measure_bound", guard, 0);
    endtask

    int n, p0;

    initial begin
        rst = 1'b1; not_r = 1'b1; c_and_l = 1'b1; en_s = 1'b1; l_or_notc = 1'b1;
        ms = 3'd0; mt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {14'd0, observed()}, 32'd0);

        // Reset release: INIT, AR_TO_N x2, N_GREEN
        @(negedge clk);
        rst = 1'b0;
        cyc(); check_eq("seq_c1", state, 1); check_eq("pulse_c1", {s_NR, s_ER, en_NR, en_EY}, 4'hF);
        cyc(); check_eq("seq_c2", state, 1);
        pulses = 0;
        cyc(); check_eq("seq_c3", state, 2); check_eq("pulse_c3", {s_NG, s_ER, en_NG}, 3'h7);

        // Full loop
        measure(3'd2, n); check_eq("ng_len", n, 8);
        measure(3'd3, n); check_eq("ny_len", n, 4);
        measure(3'd4, n); check_eq("are_len", n, 2);
        measure(3'd5, n); check_eq("eg_len", n, 8);
        measure(3'd6, n); check_eq("ey_len", n, 4);
        check_eq("loop_state", state, 1);
        check_eq("loop_pulses", pulses, 6);

        // No east demand: N_GREEN runs to its maximum
        c_and_l = 1'b0;
        measure(3'd2, n); check_eq("ng_max_len", n, 32);
        goto_state(3'd2);
        repeat (20) cyc();
        check_eq("ng_t20_state", state, 2);
        c_and_l = 1'b1;
        cyc(); check_eq("ng_late_exit", state, 3);

        // Override during E_GREEN at timer 3
        goto_state(3'd5);
        repeat (3) cyc();
        not_r = 1'b0;
        cyc();
        check_eq("ovr_state", state, 7);
        check_eq("ovr_ind", {s_IC, en_IC}, 3'b011);
        check_eq("ovr_pulse", {s_NR, s_NG, s_NY, s_ER, s_EG, s_EY, en_NR}, 7'b1001001);
        p0 = pulses;
        repeat (4) cyc();
        check_eq("ovr_no_repulse", pulses, p0);
        not_r = 1'b1;
        cyc(); check_eq("ovr_exit", state, 1);
        measure(3'd1, n); check_eq("ovr_arn_len", n, 2);
        check_eq("ovr_then_ng", state, 2);

        // Freeze during N_YELLOW at timer 1
        goto_state(3'd3);
        cyc();
        en_s = 1'b0;
        p0 = pulses;
        repeat (10) cyc();
        check_eq("frz_state", state, 3);
        check_eq("frz_pulses", pulses, p0);
        check_eq("frz_en_ic", en_IC, 0);
        en_s = 1'b1;
        measure(3'd3, n); check_eq("frz_rest_len", n, 3);

        // Asynchronous reset mid E_GREEN
        goto_state(3'd5);
        repeat (2) cyc();
        #3 rst = 1'b1;
        #1;
        check_eq("arst_outputs", {14'd0, observed()}, 32'd0);
        ms = 3'd0; mt = 0;
        @(posedge clk);
        #1;
        check_eq("arst_hold", {14'd0, observed()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(); check_eq("arst_seq1", state, 1);
        cyc(); check_eq("arst_seq2", state, 1);
        cyc(); check_eq("arst_seq3", state, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
